// File: rtl/ucmp_pipe.sv
// ucmp_pipe: pipelined unsigned magnitude comparator.
// It computes I0 - I1 as a segmented subtract-with-carry chain, SEG bits per stage.
// The relation result comes from the final carry-out and an accumulated zero flag.
//
// Optional feature: define UCMP_SIGNED_EN to add the per-transaction SIGNED input.
// With SIGNED=1, relations 0-3 are evaluated as two's-complement.
//
// Ports:
//   CLK, RESET        clock and synchronous active-high reset
//   I_VALID / I_READY input handshake (I_READY depends only on O_VALID/O_READY)
//   I0, I1            minuend / subtrahend, WIDTH bits
//   MODE              0 UGE, 1 UGT, 2 ULE, 3 ULT, 4 EQ, 5 NE, 6/7 -> 0
//   SIGNED            (UCMP_SIGNED_EN only) signed evaluation of relations 0-3
//   O_VALID / O_READY output handshake
//   O, DIFF, COUT     relation result, I0-I1 mod 2^WIDTH, raw carry-out
module ucmp_pipe #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SEG   = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             I_VALID,
  output logic             I_READY,
  input  logic [WIDTH-1:0] I0,
  input  logic [WIDTH-1:0] I1,
  input  logic [2:0]       MODE,
`ifdef UCMP_SIGNED_EN
  input  logic             SIGNED,
`endif
  output logic             O_VALID,
  input  logic             O_READY,
  output logic             O,
  output logic [WIDTH-1:0] DIFF,
  output logic             COUT
);

  localparam int unsigned STAGES = (WIDTH + SEG - 1) / SEG;
  localparam int unsigned LAST_W = WIDTH - (STAGES - 1) * SEG;

  localparam logic [2:0] MODE_UGE = 3'd0;
  localparam logic [2:0] MODE_UGT = 3'd1;
  localparam logic [2:0] MODE_ULE = 3'd2;
  localparam logic [2:0] MODE_ULT = 3'd3;
  localparam logic [2:0] MODE_EQ  = 3'd4;
  localparam logic [2:0] MODE_NE  = 3'd5;

  logic stall_c;

  // Whole pipeline freezes while the output holds an unconsumed result.
  assign stall_c = O_VALID && !O_READY;
  assign I_READY = !stall_c;

  for (genvar k = 0; k < STAGES; k++) begin : gen_stage
    localparam int unsigned LO  = k * SEG;
    localparam int unsigned W   = (k == STAGES - 1) ? LAST_W : SEG;
    localparam int unsigned RIN = WIDTH - LO;  // operand bits not yet consumed
    localparam int unsigned HI  = LO + W;      // sum bits completed after this stage

    logic [RIN-1:0] a_in;
    logic [RIN-1:0] b_in;
    logic           c_in;
    logic           z_in;
    logic           v_in;
    logic [2:0]     mode_in;
`ifdef UCMP_SIGNED_EN
    logic           sgn_in;
`endif
    logic [W:0]     sum_c;
    logic [HI-1:0]  s_d, s_q;
    logic           c_d, c_q;
    logic           z_d;
    logic           v_d, v_q;

    // Stage inputs: ports for stage 0, previous stage registers otherwise.
    if (k == 0) begin : g_src
      assign a_in    = I0;
      assign b_in    = I1;
      assign c_in    = 1'b1;
      assign z_in    = 1'b1;
      assign v_in    = I_VALID;
      assign mode_in = MODE;
`ifdef UCMP_SIGNED_EN
      assign sgn_in  = SIGNED;
`endif
      assign s_d     = sum_c[W-1:0];
    end else begin : g_src
      assign a_in    = gen_stage[k-1].g_pass.a_q;
      assign b_in    = gen_stage[k-1].g_pass.b_q;
      assign c_in    = gen_stage[k-1].c_q;
      assign z_in    = gen_stage[k-1].g_pass.z_q;
      assign v_in    = gen_stage[k-1].v_q;
      assign mode_in = gen_stage[k-1].g_pass.mode_q;
`ifdef UCMP_SIGNED_EN
      assign sgn_in  = gen_stage[k-1].g_pass.sgn_q;
`endif
      assign s_d     = {sum_c[W-1:0], gen_stage[k-1].s_q};
    end

    // Slice adder: a + ~b + carry-in.
    always_comb begin
      sum_c = {1'b0, a_in[W-1:0]} + {1'b0, ~b_in[W-1:0]} + (W+1)'(c_in);
      c_d   = sum_c[W];
      z_d   = z_in && (sum_c[W-1:0] == '0);
      v_d   = v_in;
    end

    // Payload only loads with a valid transaction, so bubbles leave it untouched.
    always_ff @(posedge CLK) begin
      if (RESET) begin
        v_q <= 1'b0;
        s_q <= '0;
        c_q <= 1'b0;
      end else if (!stall_c) begin
        v_q <= v_d;
        if (v_d) begin
          s_q <= s_d;
          c_q <= c_d;
        end
      end
    end

    // Skewed transport of the unconsumed operand bits and per-transaction side info.
    if (k < STAGES - 1) begin : g_pass
      logic [RIN-W-1:0] a_d, a_q;
      logic [RIN-W-1:0] b_d, b_q;
      logic             z_q;
      logic [2:0]       mode_q;
`ifdef UCMP_SIGNED_EN
      logic             sgn_q;
`endif

      assign a_d = a_in[RIN-1:W];
      assign b_d = b_in[RIN-1:W];

      always_ff @(posedge CLK) begin
        if (RESET) begin
          a_q    <= '0;
          b_q    <= '0;
          z_q    <= 1'b0;
          mode_q <= '0;
`ifdef UCMP_SIGNED_EN
          sgn_q  <= 1'b0;
`endif
        end else if (!stall_c && v_d) begin
          a_q    <= a_d;
          b_q    <= b_d;
          z_q    <= z_d;
          mode_q <= mode_in;
`ifdef UCMP_SIGNED_EN
          sgn_q  <= sgn_in;
`endif
        end
      end
    end

    // Relation resolved from the last slice's carry and the full zero flag.
    if (k == STAGES - 1) begin : g_res
      logic ge_c;
      logic o_d, o_q;
`ifdef UCMP_SIGNED_EN
      logic ovf_c;

      // Overflow of a + ~b: operands agree in sign but the sum does not.
      assign ovf_c = (a_in[RIN-1] == ~b_in[RIN-1]) && (sum_c[W-1] != a_in[RIN-1]);
`endif

      always_comb begin
        ge_c = c_d;
`ifdef UCMP_SIGNED_EN
        if (sgn_in) ge_c = (sum_c[W-1] == ovf_c);
`endif
        o_d = 1'b0;
        case (mode_in)
          MODE_UGE: o_d = ge_c;
          MODE_UGT: o_d = ge_c && !z_d;
          MODE_ULE: o_d = !ge_c || z_d;
          MODE_ULT: o_d = !ge_c;
          MODE_EQ:  o_d = z_d;
          MODE_NE:  o_d = !z_d;
          default:  o_d = 1'b0;
        endcase
      end

      always_ff @(posedge CLK) begin
        if (RESET) begin
          o_q <= 1'b0;
        end else if (!stall_c && v_d) begin
          o_q <= o_d;
        end
      end
    end
  end

  assign O_VALID = gen_stage[STAGES-1].v_q;
  assign DIFF    = gen_stage[STAGES-1].s_q;
  assign COUT    = gen_stage[STAGES-1].c_q;
  assign O       = gen_stage[STAGES-1].g_res.o_q;

endmodule

// File: tb/tb_ucmp_pipe.sv
// Self-checking bench for ucmp_pipe: a 16/4 instance and a 10/4 instance (uneven last slice).
module tb_ucmp_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 16-bit instance signals
  logic        iv16 = 1'b0, rdy16, ov16, ordy16 = 1'b1, o16, cout16, sg16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0, diff16;
  logic [2:0]  m16 = '0;
  // 10-bit instance signals
  logic        iv10 = 1'b0, rdy10, ov10, ordy10 = 1'b1, o10, cout10;
  logic [9:0]  a10 = '0, b10 = '0, diff10;
  logic [2:0]  m10 = '0;

  ucmp_pipe #(.WIDTH(16), .SEG(4)) u16 (
    .CLK(clk), .RESET(rst), .I_VALID(iv16), .I_READY(rdy16), .I0(a16), .I1(b16), .MODE(m16),
`ifdef UCMP_SIGNED_EN
    .SIGNED(sg16),
`endif
    .O_VALID(ov16), .O_READY(ordy16), .O(o16), .DIFF(diff16), .COUT(cout16)
  );

  ucmp_pipe #(.WIDTH(10), .SEG(4)) u10 (
    .CLK(clk), .RESET(rst), .I_VALID(iv10), .I_READY(rdy10), .I0(a10), .I1(b10), .MODE(m10),
`ifdef UCMP_SIGNED_EN
    .SIGNED(1'b0),
`endif
    .O_VALID(ov10), .O_READY(ordy10), .O(o10), .DIFF(diff10), .COUT(cout10)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the operands. Returns {o, cout, diff[15:0]}.
  function automatic logic [17:0] model(input int unsigned a, input int unsigned b,
                                        input int m, input bit sg, input int w);
    int unsigned md, d;
    int sa, sb;
    bit c, z, ge;
    logic o;
    md = 32'd1 << w;
    d  = (a + md - b) % md;
    c  = (a >= b);
    z  = (a == b);
    sa = (a >= md / 2) ? int'(a) - int'(md) : int'(a);
    sb = (b >= md / 2) ? int'(b) - int'(md) : int'(b);
    ge = sg ? (sa >= sb) : c;
    case (m)
      0: o = ge;
      1: o = ge && !z;
      2: o = !ge || z;
      3: o = !ge;
      4: o = z;
      5: o = !z;
      default: o = 1'b0;
    endcase
    return {o, c, 16'(d)};
  endfunction

  logic [17:0] q16[$];
  logic [17:0] q10[$];
  logic        em10[$];
  int          n_emit16 = 0;
  logic        last_o16 = 1'b0;
  bit          prev_stall16 = 1'b0;
  logic [17:0] prev16 = '0;

  function automatic bit sg_eff();
`ifdef UCMP_SIGNED_EN
    return sg16;
`else
    return 1'b0;
`endif
  endfunction

  // Compare process: handshake rule, hold-under-stall, in-order results, and model capture.
  always @(negedge clk) begin
    if (!rst) begin
      logic [17:0] exp;
      chk("i_ready16", 32'(rdy16), 32'(!(ov16 && !ordy16)));
      chk("i_ready10", 32'(rdy10), 32'(!(ov10 && !ordy10)));
      if (prev_stall16) chk("hold16", 32'({o16, cout16, diff16}), 32'(prev16));
      if (ov16 && ordy16) begin
        if (q16.size() == 0) chk("emit16_unexpected", 32'(1), 32'(0));
        else begin
          exp = q16.pop_front();
          chk("result16", 32'({o16, cout16, diff16}), 32'(exp));
        end
        n_emit16++;
        last_o16 = o16;
      end
      if (ov10 && ordy10) begin
        if (q10.size() == 0) chk("emit10_unexpected", 32'(1), 32'(0));
        else begin
          exp = q10.pop_front();
          chk("result10", 32'({o10, cout10, 6'd0, diff10}), 32'({exp[17:16], 6'd0, exp[9:0]}));
        end
        em10.push_back(o10);
      end
      if (iv16 && rdy16) q16.push_back(model(32'(a16), 32'(b16), int'(m16), sg_eff(), 16));
      if (iv10 && rdy10) q10.push_back(model(32'(a10), 32'(b10), int'(m10), 1'b0, 10));
      prev_stall16 = ov16 && !ordy16;
      prev16 = {o16, cout16, diff16};
    end
  end

  // Present one transaction (keeps I_VALID high on return) and wait for its accept edge.
  task automatic send(input bit w10, input logic [15:0] a, input logic [15:0] b,
                      input logic [2:0] m, input bit sg);
    int n = 0;
    if (w10) begin iv10 = 1'b1; a10 = a[9:0]; b10 = b[9:0]; m10 = m; end
    else     begin iv16 = 1'b1; a16 = a; b16 = b; m16 = m; sg16 = sg; end
    forever begin
      @(negedge clk);
      if (w10 ? rdy10 : rdy16) break;
      n++;
      if (n > 200) begin
        chk("send_timeout", 32'(1), 32'(0));
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    iv16 = 1'b0;
    iv10 = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [7:0] lit10 = 8'b0010_0011;
  logic [17:0] r;

  initial begin
    int n;
    int base;
    // Pin the model with hand-computed values.
    r = model(32'h1234, 32'h1233, 1, 1'b0, 16); chk("model_ugt", 32'(r), 32'h3_0001);
    r = model(32'h0000, 32'h0001, 3, 1'b0, 16); chk("model_ult", 32'(r), 32'h2_FFFF);
    r = model(32'hFFFF, 32'hFFFF, 4, 1'b0, 16); chk("model_eq",  32'(r), 32'h3_0000);
    r = model(32'hFFFF, 32'h0001, 3, 1'b1, 16); chk("model_sult", 32'(r[17]), 32'(1));
    r = model(32'hFFFF, 32'h0001, 3, 1'b0, 16); chk("model_uult", 32'(r[17]), 32'(0));
    r = model(32'h200, 32'h1FF, 2, 1'b0, 10);   chk("model_w10", 32'(r), 32'h1_0001);

    // Reset with I_VALID high: nothing may be captured.
    iv16 = 1'b1; a16 = 16'h5555; b16 = 16'h0F0F; m16 = 3'd0;
    iv10 = 1'b1; a10 = 10'h155;  b10 = 10'h0AA;  m10 = 3'd0;
    repeat (2) begin
      @(negedge clk);
      chk("rst_o_valid", 32'(ov16), 32'(0));
      chk("rst_o", 32'(o16), 32'(0));
      chk("rst_diff", 32'(diff16), 32'(0));
      chk("rst_cout", 32'(cout16), 32'(0));
      chk("rst_i_ready", 32'(rdy16), 32'(1));
      chk("rst_o_valid10", 32'(ov10), 32'(0));
    end
    @(posedge clk); #1;
    rst = 1'b0; iv16 = 1'b0; iv10 = 1'b0;
    idle(8);
    @(negedge clk);
    chk("post_rst_o_valid", 32'(ov16), 32'(0));
    chk("post_rst_diff", 32'(diff16), 32'(0));
    chk("post_rst_emits", 32'(n_emit16), 32'(0));

    // Latency: presented in cycle t, valid after the fourth edge.
    @(posedge clk); #1;
    iv16 = 1'b1; a16 = 16'h1234; b16 = 16'h1233; m16 = 3'd1; sg16 = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      iv16 = 1'b0;
    end while (!ov16 && n < 20);
    chk("latency", 32'(n), 32'(4));
    chk("lat_o", 32'(o16), 32'(1));
    chk("lat_diff", 32'(diff16), 32'h0001);
    chk("lat_cout", 32'(cout16), 32'(1));
    idle(2);

    // Full carry ripple.
    send(1'b0, 16'h0000, 16'h0001, 3'd3, 1'b0);
    send(1'b0, 16'hFFFF, 16'hFFFF, 3'd4, 1'b0);
    idle(6);

    // Streaming with a 3-cycle backpressure window.
    base = n_emit16;
    fork
      begin
        send(1'b0, 16'h8000, 16'h7FFF, 3'd0, 1'b0);
        send(1'b0, 16'h0001, 16'h0002, 3'd1, 1'b0);
        send(1'b0, 16'hABCD, 16'hABCD, 3'd2, 1'b0);
        send(1'b0, 16'h00F0, 16'h0F00, 3'd3, 1'b0);
        send(1'b0, 16'h1111, 16'h1111, 3'd5, 1'b0);
        send(1'b0, 16'hFFFF, 16'h0000, 3'd1, 1'b0);
        send(1'b0, 16'h0010, 16'h000F, 3'd6, 1'b0);
        send(1'b0, 16'h7777, 16'h8888, 3'd2, 1'b0);
        iv16 = 1'b0;
      end
      begin
        repeat (5) @(posedge clk);
        #1 ordy16 = 1'b0;
        repeat (3) @(posedge clk);
        #1 ordy16 = 1'b1;
      end
    join
    idle(10);
    chk("stream_count", 32'(n_emit16 - base), 32'(8));

    // Uneven last slice, all modes.
    for (int m = 0; m < 8; m++) send(1'b1, 16'h0200, 16'h01FF, 3'(m), 1'b0);
    iv10 = 1'b0;
    idle(8);
    chk("w10_count", 32'(em10.size()), 32'(8));
    for (int m = 0; m < 8; m++)
      if (m < em10.size()) chk("w10_mode", 32'(em10[m]), 32'(lit10[m]));

`ifdef UCMP_SIGNED_EN
    send(1'b0, 16'hFFFF, 16'h0001, 3'd3, 1'b1);
    idle(6);
    chk("signed_ult", 32'(last_o16), 32'(1));
    send(1'b0, 16'hFFFF, 16'h0001, 3'd3, 1'b0);
    idle(6);
    chk("unsigned_ult", 32'(last_o16), 32'(0));
`endif

    n = 0;
    while ((q16.size() != 0 || q10.size() != 0) && n < 50) begin
      @(posedge clk);
      n++;
    end
    chk("drain16", 32'(q16.size()), 32'(0));
    chk("drain10", 32'(q10.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ucmp_pipe.md
# ucmp_pipe

Parametrised, pipelined unsigned magnitude comparator built on a segmented subtract-with-carry chain. It computes I0 − I1 (carry-in 1) a SEG-bit slice per pipeline stage and resolves one of six relations from the final carry-out and an accumulated zero flag. It is the wide, high-Fmax successor of the combinational 2-bit UGE cell. It sits between datapath producers and consumers behind a valid/ready handshake with full backpressure.

## Interface
- WIDTH, 16, operand width in bits; ≥ 2.
- SEG, 4, bits resolved per pipeline stage; 1 ≤ SEG ≤ WIDTH. STAGES = ceil(WIDTH/SEG).
- CLK  input  1  rising-edge clock; the only clock.
- RESET  input  1  synchronous, active-high reset.
- I_VALID  input  1  input transaction valid.
- I_READY  output  1  block accepts input this cycle.
- I0  input  WIDTH  minuend operand.
- I1  input  WIDTH  subtrahend operand.
- MODE  input  3  relation: 0 UGE, 1 UGT, 2 ULE, 3 ULT, 4 EQ, 5 NE; 6 and 7 return O=0.
- O_VALID  output  1  result valid.
- O_READY  input  1  consumer accepts the result.
- O  output  1  relation result.
- DIFF  output  WIDTH  I0 − I1 modulo 2^WIDTH.
- COUT  output  1  final carry-out; 1 ⇔ I0 ≥ I1.

## Operation
- Accept: transfer when I_VALID && I_READY. Emit: transfer when O_VALID && O_READY.
- Stall: stall = O_VALID && !O_READY. I_READY = !stall. On stall every stage register holds; otherwise the pipeline advances, inserting a bubble when I_VALID=0.
- Stage k (0..STAGES−1) adds slice k of I0 and ~I1 plus the carry from stage k−1 (stage 0 carry-in = 1). It registers the SEG-bit sum slice, carry, zero flag (Zk = Zk−1 && slice==0, Z−1 = 1), valid bit and MODE.
- Unprocessed operand slices and completed sum slices travel skewed in stage registers so DIFF emerges aligned. The last slice is WIDTH − (STAGES−1)·SEG bits; its carry-out is COUT.
- Result from C = COUT and Z = zero flag of DIFF: UGE = C; UGT = C && !Z; ULE = !C || Z; ULT = !C; EQ = Z; NE = !Z.
- Reset: all stage valid bits cleared and in-flight data discarded. O_VALID=0, O=0, COUT=0, DIFF=0, I_READY=1 during and after reset. I_VALID is ignored while RESET=1.

## Timing
- Latency: STAGES cycles from accept edge to O_VALID (WIDTH=16, SEG=4 → 4). With SEG=WIDTH: 1 cycle.
- Throughput: one transaction per cycle with O_READY held high.
- O, DIFF and COUT are registered and stable while O_VALID && !O_READY.
- I_READY is combinational from O_VALID/O_READY only; there is no path from I_VALID to I_READY.
- Accept and emit in the same cycle while not stalled: both occur, and occupancy is unchanged.
- Reset asserted mid-stall: pipeline flushes on that edge; the held result is lost.

## Configuration
- UCMP_SIGNED_EN defined: adds input SIGNED (1 bit), carried per transaction through the pipeline. When SIGNED=1, relations 0–3 are evaluated two's-complement: GE = (N == V), with N = DIFF MSB and V = overflow of the last slice. EQ/NE and DIFF are unchanged. COUT still reports the raw carry.
- UCMP_SIGNED_EN undefined: no SIGNED port; all relations are unsigned.

## Test plan
- Reset: assert RESET 2 cycles while I_VALID=1 -> O_VALID=0, O=0, DIFF=0, COUT=0, I_READY=1; nothing emitted afterwards.
- Latency/basic (16/4): I0=0x1234, I1=0x1233, MODE=UGT at cycle t -> O_VALID at t+4, O=1, DIFF=0x0001, COUT=1.
- Carry ripple across all segments: I0=0x0000, I1=0x0001, MODE=ULT -> O=1, DIFF=0xFFFF, COUT=0. I0=I1=0xFFFF, MODE=EQ -> O=1, DIFF=0, COUT=1.
- Streaming with backpressure: 8 back-to-back transactions, O_READY low for 3 cycles mid-stream -> I_READY low exactly while O_VALID && !O_READY; all 8 results emerge in order, none lost or duplicated.
- All modes and the uneven last slice (WIDTH=10, SEG=4): I0=0x200, I1=0x1FF across MODE 0–7 -> 1,1,0,0,0,1,0,0.
- Signed (UCMP_SIGNED_EN, 16/4): I0=0xFFFF, I1=0x0001, SIGNED=1, MODE=ULT -> O=1. Same operands with SIGNED=0 -> O=0.
